// File: rtl/crc24b_attach_pkg.sv
// Shared constants and FSM state type for the CRC24B attach block.
// The CRC engine and the top both import from here so the polynomial lives in one place.
package crc24b_attach_pkg;

    localparam logic [23:0] CRC_POLY      = 24'h800063;
    localparam int          SMALL_PAYLOAD = 129;
    localparam int          LARGE_PAYLOAD = 765;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC     = 2'd2
    } state_t;

endpackage

// File: rtl/crc24b_byte.sv
// One-byte CRC24B update: eight MSB-first LFSR steps, non-reflected, no final XOR.
module crc24b_byte #(
    parameter logic [23:0] POLY = crc24b_attach_pkg::CRC_POLY
) (
    input  logic [23:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [23:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (crc_out[23] ^ data_byte[i]) begin
                crc_out = {crc_out[22:0], 1'b0} ^ POLY;
            end else begin
                crc_out = {crc_out[22:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/crc24b_attach.sv
// Passes a small or large payload block through with one cycle of latency and appends
// its 24-bit CRC (MSB byte first), framing the block with CRC_start / CRC_end pulses.
module crc24b_attach
    import crc24b_attach_pkg::state_t,
           crc24b_attach_pkg::ST_IDLE,
           crc24b_attach_pkg::ST_PAYLOAD,
           crc24b_attach_pkg::ST_CRC;
#(
    parameter logic [23:0] CRC_POLY      = crc24b_attach_pkg::CRC_POLY,
    parameter int          SMALL_PAYLOAD = crc24b_attach_pkg::SMALL_PAYLOAD,
    parameter int          LARGE_PAYLOAD = crc24b_attach_pkg::LARGE_PAYLOAD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       in_valid,
    input  logic       in_start,
    input  logic       in_blocksize,
    output logic       in_ready,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       CRC_start,
    output logic       CRC_blocksize,
    output logic       CRC_end,
    output state_t     state
);

    // Handshake: a byte transfers on a cycle with in_valid && in_ready; in IDLE it must
    // also carry in_start or it is dropped. The output side has no back-pressure.

    localparam logic [9:0] SMALL_LEN = 10'(SMALL_PAYLOAD);
    localparam logic [9:0] LARGE_LEN = 10'(LARGE_PAYLOAD);

    logic [23:0] crc;
    logic [23:0] crc_seed;
    logic [23:0] crc_next;
    logic [9:0]  count;
    logic [9:0]  block_len;
    logic        start_accept;
    logic        pay_accept;

    assign start_accept = (state == ST_IDLE) && in_valid && in_start;
    assign pay_accept   = (state == ST_PAYLOAD) && in_valid;
    assign crc_seed     = start_accept ? 24'h000000 : crc;
    assign block_len    = CRC_blocksize ? LARGE_LEN : SMALL_LEN;

    crc24b_byte #(
        .POLY (CRC_POLY)
    ) u_crc24b_byte (
        .crc_in    (crc_seed),
        .data_byte (data_in),
        .crc_out   (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= 10'd0;
            crc           <= 24'h000000;
            data_out      <= 8'h00;
            out_valid     <= 1'b0;
            CRC_start     <= 1'b0;
            CRC_end       <= 1'b0;
            CRC_blocksize <= 1'b0;
            in_ready      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            CRC_start <= 1'b0;
            CRC_end   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        CRC_blocksize <= in_blocksize;
                        crc           <= crc_next;
                        count         <= 10'd1;
                        data_out      <= data_in;
                        out_valid     <= 1'b1;
                        CRC_start     <= 1'b1;
                        state         <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pay_accept) begin
                        crc       <= crc_next;
                        data_out  <= data_in;
                        out_valid <= 1'b1;
                        if (count + 10'd1 == block_len) begin
                            // count is reused as the CRC byte index from here on
                            count    <= 10'd0;
                            in_ready <= 1'b0;
                            state    <= ST_CRC;
                        end else begin
                            count <= count + 10'd1;
                        end
                    end
                end
                ST_CRC: begin
                    out_valid <= 1'b1;
                    count     <= count + 10'd1;
                    case (count[1:0])
                        2'd0:    data_out <= crc[23:16];
                        2'd1:    data_out <= crc[15:8];
                        default: begin
                            data_out <= crc[7:0];
                            CRC_end  <= 1'b1;
                            count    <= 10'd0;
                            in_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    endcase
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc24b_attach.sv
// Self-checking bench for crc24b_attach: random payloads, polynomial-division CRC model,
// output scoreboard with expected byte / frame-flag / block-size queues.
module tb_crc24b_attach;
    import crc24b_attach_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_start = 1'b0;
    logic       in_blocksize = 1'b0;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;
    logic       CRC_start;
    logic       CRC_blocksize;
    logic       CRC_end;
    state_t     state;

    logic [23:0] u_crc_in = 24'h0;
    logic [7:0]  u_byte = 8'h0;
    logic [23:0] u_crc_out;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    crc24b_attach dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .in_valid      (in_valid),
        .in_start      (in_start),
        .in_blocksize  (in_blocksize),
        .in_ready      (in_ready),
        .data_out      (data_out),
        .out_valid     (out_valid),
        .CRC_start     (CRC_start),
        .CRC_blocksize (CRC_blocksize),
        .CRC_end       (CRC_end),
        .state         (state)
    );

    crc24b_byte u_unit (
        .crc_in    (u_crc_in),
        .data_byte (u_byte),
        .crc_out   (u_crc_out)
    );

    // ---------------- reference model ----------------
    // CRC as the remainder of M(x) * x^24 divided by the generator, by long division.
    function automatic logic [23:0] crc_model(input byte_q_t msg);
        logic [24:0] r;
        int nbits;
        r = 25'd0;
        nbits = msg.size() * 8 + 24;
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] cur;
            logic b;
            b = 1'b0;
            if (i < msg.size() * 8) begin
                cur = msg[i / 8];
                b = cur[7 - (i % 8)];
            end
            r = {r[23:0], b};
            if (r[24]) r = r ^ {1'b1, CRC_POLY};
        end
        return r[23:0];
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [1:0] exp_f_q[$];
    logic       exp_bs_q[$];

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int end_cnt = 0;
    int out_cnt = 0;
    int ready_low = 0;
    int start_cyc_q[$];
    int end_cyc_q[$];
    int bub_slots = 0;
    int bub_ov = 0;
    int bub_held_bad = 0;

    logic [7:0] sb_b;
    logic [1:0] sb_f;
    logic       sb_bs;

    task automatic push_expected(input byte_q_t msg, input logic bs, input bit full);
        logic [23:0] c;
        for (int i = 0; i < msg.size(); i++) begin
            exp_q.push_back(msg[i]);
            exp_f_q.push_back({(i == 0), 1'b0});
            exp_bs_q.push_back(bs);
        end
        if (full) begin
            c = crc_model(msg);
            exp_q.push_back(c[23:16]); exp_f_q.push_back(2'b00); exp_bs_q.push_back(bs);
            exp_q.push_back(c[15:8]);  exp_f_q.push_back(2'b00); exp_bs_q.push_back(bs);
            exp_q.push_back(c[7:0]);   exp_f_q.push_back(2'b01); exp_bs_q.push_back(bs);
        end
    endtask

    always @(negedge clk) begin
        if (in_ready === 1'b0) ready_low++;
        if (CRC_start === 1'b1) begin start_cnt++; start_cyc_q.push_back(cyc); end
        if (CRC_end === 1'b1) begin end_cnt++; end_cyc_q.push_back(cyc); end
        if (out_valid === 1'b1) begin
            out_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got byte %h start=%b end=%b, required no output", data_out, CRC_start, CRC_end);
            end else begin
                sb_b = exp_q.pop_front();
                sb_f = exp_f_q.pop_front();
                sb_bs = exp_bs_q.pop_front();
                if (data_out !== sb_b || {CRC_start, CRC_end} !== sb_f || CRC_blocksize !== sb_bs) begin
                    bad++;
                    $display("FAIL sb_byte out#%0d: got %h se=%b bs=%b, required %h se=%b bs=%b",
                             out_cnt, data_out, {CRC_start, CRC_end}, CRC_blocksize, sb_b, sb_f, sb_bs);
                end
            end
        end else if (CRC_start === 1'b1 || CRC_end === 1'b1) begin
            total++;
            bad++;
            $display("FAIL frame_no_valid: start=%b end=%b with out_valid=%b, required no pulse", CRC_start, CRC_end, out_valid);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_block(input byte_q_t msg, input int n, input logic bs, input bit bubble);
        int i;
        int k;
        int w;
        i = 0;
        k = 0;
        while (i < n) begin
            w = 0;
            while (in_ready !== 1'b1 && w < 20) begin
                in_valid = 1'b0;
                in_start = 1'b0;
                @(posedge clk); #1;
                w++;
            end
            if (bubble && (k % 3 == 2)) begin
                in_valid = 1'b0;
                in_start = 1'b0;
                data_in = 8'($urandom);
                @(posedge clk); #1;
                bub_slots++;
                if (out_valid !== 1'b0) bub_ov++;
                if (data_out !== msg[i - 1]) bub_held_bad++;
            end else begin
                in_valid = 1'b1;
                in_start = (i == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
                in_blocksize = (i == 0) ? bs : 1'($urandom);
                data_in = msg[i];
                @(posedge clk); #1;
                i++;
            end
            k++;
        end
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic wait_end(input int target, output bit ok);
        int n;
        n = 0;
        while (end_cnt < target && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (end_cnt >= target);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic byte_q_t rand_msg(input int n);
        byte_q_t m;
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int o0;
        reset = 1'b1; in_valid = 1'b1; in_start = 1'b1; in_blocksize = 1'b1; data_in = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data_out: got %h, required 00", data_out); end
        total++; if (CRC_start !== 1'b0) begin bad++; $display("FAIL rst_crc_start: got %b, required 0", CRC_start); end
        total++; if (CRC_end !== 1'b0) begin bad++; $display("FAIL rst_crc_end: got %b, required 0", CRC_end); end
        total++; if (CRC_blocksize !== 1'b0) begin bad++; $display("FAIL rst_blocksize: got %b, required 0", CRC_blocksize); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d, required IDLE", state); end
        reset = 1'b0;
        o0 = out_cnt;
        in_start = 1'b0;
        repeat (3) begin
            data_in = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (out_cnt != o0) begin bad++; $display("FAIL idle_discard: got %0d outputs, required 0", out_cnt - o0); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL idle_discard_state: got %0d, required IDLE", state); end
    endtask

    task automatic test_unit_byte();
        byte_q_t m;
        logic [7:0] b0;
        logic [7:0] b1;
        u_crc_in = 24'h0; u_byte = 8'h01; #1;
        total++; if (u_crc_out !== 24'h800063) begin bad++; $display("FAIL unit_01: got %h, required 800063", u_crc_out); end
        for (int t = 0; t < 4; t++) begin
            b0 = 8'($urandom); b1 = 8'($urandom);
            m = {};
            m.push_back(b0); m.push_back(b1);
            u_crc_in = 24'h0; u_byte = b0; #1;
            u_crc_in = u_crc_out; u_byte = b1; #1;
            total++;
            if (u_crc_out !== crc_model(m)) begin
                bad++; $display("FAIL unit_chain %h %h: got %h, required %h", b0, b1, u_crc_out, crc_model(m));
            end
        end
    endtask

    task automatic test_small_zeros();
        byte_q_t m;
        int o0, s0, e0;
        bit ok;
        for (int i = 0; i < SMALL_PAYLOAD; i++) m.push_back(8'h00);
        o0 = out_cnt; s0 = start_cnt; e0 = end_cnt; ready_low = 0;
        push_expected(m, 1'b0, 1'b1);
        drive_block(m, m.size(), 1'b0, 1'b0);
        wait_end(e0 + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL zeros_timeout: end_cnt=%0d, required %0d", end_cnt, e0 + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zeros_left: %0d bytes missing, required 0", exp_q.size()); end
        total++; if (out_cnt - o0 != 132) begin bad++; $display("FAIL zeros_count: got %0d, required 132", out_cnt - o0); end
        total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL zeros_starts: got %0d, required 1", start_cnt - s0); end
        total++; if (ready_low != 3) begin bad++; $display("FAIL zeros_ready_low: got %0d, required 3", ready_low); end
    endtask

    task automatic test_single_80();
        byte_q_t m;
        int e0;
        bit ok;
        m.push_back(8'h80);
        for (int i = 1; i < SMALL_PAYLOAD; i++) m.push_back(8'h00);
        e0 = end_cnt;
        push_expected(m, 1'b0, 1'b1);
        drive_block(m, m.size(), 1'b0, 1'b0);
        wait_end(e0 + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL b80_timeout: end_cnt=%0d, required %0d", end_cnt, e0 + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b80_left: %0d bytes missing, required 0", exp_q.size()); end
    endtask

    task automatic test_bubbles();
        byte_q_t m;
        int o0, e0;
        bit ok;
        m = rand_msg(SMALL_PAYLOAD);
        o0 = out_cnt; e0 = end_cnt;
        bub_slots = 0; bub_ov = 0; bub_held_bad = 0;
        push_expected(m, 1'b0, 1'b1);
        drive_block(m, m.size(), 1'b0, 1'b1);
        wait_end(e0 + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL bub_timeout: end_cnt=%0d, required %0d", end_cnt, e0 + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bub_left: %0d bytes missing, required 0", exp_q.size()); end
        total++; if (out_cnt - o0 != 132) begin bad++; $display("FAIL bub_count: got %0d, required 132", out_cnt - o0); end
        total++; if (bub_slots != 64) begin bad++; $display("FAIL bub_slots: got %0d, required 64", bub_slots); end
        total++; if (bub_ov != 0) begin bad++; $display("FAIL bub_out_valid: got %0d high bubbles, required 0", bub_ov); end
        total++; if (bub_held_bad != 0) begin bad++; $display("FAIL bub_held: got %0d changed, required 0", bub_held_bad); end
    endtask

    task automatic test_large_random();
        byte_q_t m;
        int o0, e0;
        bit ok;
        m = rand_msg(LARGE_PAYLOAD);
        o0 = out_cnt; e0 = end_cnt;
        push_expected(m, 1'b1, 1'b1);
        drive_block(m, m.size(), 1'b1, 1'b0);
        wait_end(e0 + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL large_timeout: end_cnt=%0d, required %0d", end_cnt, e0 + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL large_left: %0d bytes missing, required 0", exp_q.size()); end
        total++; if (out_cnt - o0 != 768) begin bad++; $display("FAIL large_count: got %0d, required 768", out_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        byte_q_t m1;
        byte_q_t m2;
        int e0;
        bit ok;
        m1 = rand_msg(SMALL_PAYLOAD);
        m2 = rand_msg(SMALL_PAYLOAD);
        e0 = end_cnt;
        start_cyc_q = {}; end_cyc_q = {};
        ready_low = 0;
        push_expected(m1, 1'b0, 1'b1);
        push_expected(m2, 1'b0, 1'b1);
        drive_block(m1, m1.size(), 1'b0, 1'b0);
        drive_block(m2, m2.size(), 1'b0, 1'b0);
        wait_end(e0 + 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: end_cnt=%0d, required %0d", end_cnt, e0 + 2); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_left: %0d bytes missing, required 0", exp_q.size()); end
        total++; if (ready_low != 6) begin bad++; $display("FAIL b2b_ready_low: got %0d, required 6", ready_low); end
        total++;
        if (start_cyc_q.size() != 2 || end_cyc_q.size() != 2) begin
            bad++; $display("FAIL b2b_pulses: got %0d starts %0d ends, required 2 and 2", start_cyc_q.size(), end_cyc_q.size());
        end else if (start_cyc_q[1] != end_cyc_q[0] + 1) begin
            bad++; $display("FAIL b2b_gap: second start at %0d, required %0d", start_cyc_q[1], end_cyc_q[0] + 1);
        end
    endtask

    task automatic test_reset_abort();
        byte_q_t m;
        byte_q_t part;
        int o0, e0;
        bit ok;
        m = rand_msg(LARGE_PAYLOAD);
        for (int i = 0; i < 50; i++) part.push_back(m[i]);
        e0 = end_cnt;
        push_expected(part, 1'b1, 1'b0);
        drive_block(m, 50, 1'b1, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_start = 1'b1; in_blocksize = 1'b1; data_in = 8'($urandom);
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b, required 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid: got %b, required 0", out_valid); end
        total++; if (CRC_blocksize !== 1'b0) begin bad++; $display("FAIL abort_blocksize: got %b, required 0", CRC_blocksize); end
        total++; if (state !== ST_IDLE) begin bad++; $display("FAIL abort_state: got %0d, required IDLE", state); end
        reset = 1'b0; in_start = 1'b0;
        repeat (2) begin
            data_in = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (end_cnt != e0) begin bad++; $display("FAIL abort_no_end: got %0d ends, required 0", end_cnt - e0); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_left: %0d bytes missing, required 0", exp_q.size()); end
        m = rand_msg(LARGE_PAYLOAD);
        o0 = out_cnt;
        push_expected(m, 1'b1, 1'b1);
        drive_block(m, m.size(), 1'b1, 1'b0);
        wait_end(e0 + 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL abort2_timeout: end_cnt=%0d, required %0d", end_cnt, e0 + 1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort2_left: %0d bytes missing, required 0", exp_q.size()); end
        total++; if (out_cnt - o0 != 768) begin bad++; $display("FAIL abort2_count: got %0d, required 768", out_cnt - o0); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unit_byte();
        test_small_zeros();
        test_single_80();
        test_bubbles();
        test_large_random();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
